// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between instruction fetch
// (reads only) and the memory stage (loads/stores). Grants one request per
// cycle with the memory stage as the default winner, guards fetch against
// starvation, and routes read responses back through an in-order tracker.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid_i,
    input  logic [63:0] if_req_addr_i,
    output logic        if_req_ready_o,
    output logic        if_resp_valid_o,
    output logic [63:0] if_resp_data_o,
    input  logic        dm_req_valid_i,
    input  logic [63:0] dm_req_addr_i,
    input  logic        dm_req_wr_i,
    input  logic [63:0] dm_req_wr_data_i,
    input  logic [7:0]  dm_req_mask_i,
    output logic        dm_req_ready_o,
    output logic        dm_resp_valid_o,
    output logic [63:0] dm_resp_data_o,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [63:0] mem_wr_data_o,
    output logic [7:0]  mem_mask_o,
    input  logic        mem_resp_valid_i,
    input  logic [63:0] mem_resp_data_i,
    output logic        mem_resp_ready_o,
    input  logic        flush_i,
    output logic        resp_err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_FULL   = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] C_STARVE = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] C_LAST   = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } src_e;

    // Tracker storage: one bit per slot for source and discard flag.
    logic [MAX_OUTSTANDING-1:0] r_src;
    logic [MAX_OUTSTANDING-1:0] r_disc;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CW-1:0]              r_count;
    logic [SW-1:0]              r_starve;

    logic w_full;
    logic w_empty;
    logic w_if_elig;
    logic w_dm_elig;
    logic w_if_win;
    logic w_dm_win;
    logic w_xfer;
    logic w_push;
    src_e w_push_src;
    logic w_pop;
    src_e w_head_src;
    logic w_head_disc;
    logic w_deliver;

    // Arbitration, request steering and response routing.
    always_comb begin
        w_full      = (r_count == C_FULL);
        w_empty     = (r_count == '0);
        w_if_elig   = if_req_valid_i & ~w_full & ~flush_i;
        w_dm_elig   = dm_req_valid_i & (dm_req_wr_i | ~w_full) & ~flush_i;
        w_if_win    = w_if_elig & (~w_dm_elig | (r_starve == C_STARVE));
        w_dm_win    = w_dm_elig & ~w_if_win;
        w_xfer      = (w_if_win | w_dm_win) & mem_ready_i & ~reset;
        w_push      = w_xfer & (w_if_win | ~dm_req_wr_i);
        w_push_src  = w_if_win ? SRC_IF : SRC_DM;
        w_pop       = mem_resp_valid_i & ~w_empty & ~reset;
        w_head_src  = src_e'(r_src[r_rptr]);
        w_head_disc = r_disc[r_rptr];
        w_deliver   = w_pop & ~w_head_disc & ~flush_i;

        if_req_ready_o   = w_if_win & mem_ready_i & ~reset;
        dm_req_ready_o   = w_dm_win & mem_ready_i & ~reset;
        mem_req_o        = w_xfer;
        mem_addr_o       = '0;
        mem_wr_o         = 1'b0;
        mem_wr_data_o    = '0;
        mem_mask_o       = '0;
        if (w_xfer && w_if_win) begin
            mem_addr_o = if_req_addr_i;
        end else if (w_xfer) begin
            mem_addr_o = dm_req_addr_i;
            if (dm_req_wr_i) begin
                mem_wr_o      = 1'b1;
                mem_wr_data_o = dm_req_wr_data_i;
                mem_mask_o    = dm_req_mask_i;
            end
        end

        if_resp_valid_o  = w_deliver & (w_head_src == SRC_IF);
        dm_resp_valid_o  = w_deliver & (w_head_src == SRC_DM);
        if_resp_data_o   = mem_resp_data_i;
        dm_resp_data_o   = mem_resp_data_i;
        mem_resp_ready_o = 1'b1;
        resp_err_o       = mem_resp_valid_i & w_empty & ~reset;
    end

    // In-order read tracker: push on read transfer, pop on response, flush marks discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src   <= '0;
            r_disc  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (flush_i) begin
                r_disc <= '1;
            end
            if (w_push) begin
                r_src[r_wptr]  <= w_push_src;
                r_disc[r_wptr] <= 1'b0;
                r_wptr         <= (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Starvation counter: counts dm wins over an eligible fetch, cleared by a fetch transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_xfer && w_if_win) begin
            r_starve <= '0;
        end else if (w_xfer && w_dm_win && w_if_elig && (r_starve != C_STARVE)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int MAXO = 2;
    localparam int LIM  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid_i;
    logic [63:0] if_req_addr_i;
    logic        if_req_ready_o;
    logic        if_resp_valid_o;
    logic [63:0] if_resp_data_o;
    logic        dm_req_valid_i;
    logic [63:0] dm_req_addr_i;
    logic        dm_req_wr_i;
    logic [63:0] dm_req_wr_data_i;
    logic [7:0]  dm_req_mask_i;
    logic        dm_req_ready_o;
    logic        dm_resp_valid_o;
    logic [63:0] dm_resp_data_o;
    logic        mem_ready_i;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_wr_o;
    logic [63:0] mem_wr_data_o;
    logic [7:0]  mem_mask_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_resp_data_i;
    logic        mem_resp_ready_o;
    logic        flush_i;
    logic        resp_err_o;

    mem_port_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .STARVE_LIMIT   (LIM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_req_valid_i  (if_req_valid_i),
        .if_req_addr_i   (if_req_addr_i),
        .if_req_ready_o  (if_req_ready_o),
        .if_resp_valid_o (if_resp_valid_o),
        .if_resp_data_o  (if_resp_data_o),
        .dm_req_valid_i  (dm_req_valid_i),
        .dm_req_addr_i   (dm_req_addr_i),
        .dm_req_wr_i     (dm_req_wr_i),
        .dm_req_wr_data_i(dm_req_wr_data_i),
        .dm_req_mask_i   (dm_req_mask_i),
        .dm_req_ready_o  (dm_req_ready_o),
        .dm_resp_valid_o (dm_resp_valid_o),
        .dm_resp_data_o  (dm_resp_data_o),
        .mem_ready_i     (mem_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wr_o        (mem_wr_o),
        .mem_wr_data_o   (mem_wr_data_o),
        .mem_mask_o      (mem_mask_o),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i (mem_resp_data_i),
        .mem_resp_ready_o(mem_resp_ready_o),
        .flush_i         (flush_i),
        .resp_err_o      (resp_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        if_req_valid_i   = 1'b0;
        if_req_addr_i    = '0;
        dm_req_valid_i   = 1'b0;
        dm_req_addr_i    = '0;
        dm_req_wr_i      = 1'b0;
        dm_req_wr_data_i = '0;
        dm_req_mask_i    = '0;
        mem_ready_i      = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        flush_i          = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next();
        next();
        reset = 1'b0;
        #1;
    endtask

    // Vector record: inputs and expected {if_rdy, dm_rdy, req, wr, if_rv, dm_rv, err}
    typedef struct packed {
        logic       ifv;
        logic       dmv;
        logic       dmwr;
        logic       rdy;
        logic       rv;
        logic       fl;
        logic [6:0] exp;
    } vec_t;

    typedef struct packed {
        bit src;   // 1 = memory stage
        bit disc;
    } ent_t;

    vec_t tbl [12];
    ent_t q[$];
    int   starve;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{ifv:1, dmv:1, dmwr:0, rdy:1, rv:0, fl:0, exp:7'b0110000};
        tbl[1]  = '{ifv:1, dmv:0, dmwr:0, rdy:1, rv:0, fl:0, exp:7'b1010000};
        tbl[2]  = '{ifv:1, dmv:1, dmwr:0, rdy:1, rv:0, fl:0, exp:7'b0000000};
        tbl[3]  = '{ifv:0, dmv:0, dmwr:0, rdy:0, rv:1, fl:0, exp:7'b0000010};
        tbl[4]  = '{ifv:0, dmv:0, dmwr:0, rdy:0, rv:1, fl:0, exp:7'b0000100};
        tbl[5]  = '{ifv:0, dmv:0, dmwr:0, rdy:0, rv:1, fl:0, exp:7'b0000001};
        tbl[6]  = '{ifv:1, dmv:0, dmwr:0, rdy:0, rv:0, fl:0, exp:7'b0000000};
        tbl[7]  = '{ifv:1, dmv:1, dmwr:1, rdy:1, rv:0, fl:0, exp:7'b0111000};
        tbl[8]  = '{ifv:1, dmv:0, dmwr:0, rdy:1, rv:1, fl:0, exp:7'b1010001};
        tbl[9]  = '{ifv:0, dmv:1, dmwr:0, rdy:1, rv:1, fl:0, exp:7'b0110100};
        tbl[10] = '{ifv:1, dmv:0, dmwr:0, rdy:1, rv:1, fl:1, exp:7'b0000000};
        tbl[11] = '{ifv:0, dmv:0, dmwr:0, rdy:0, rv:1, fl:0, exp:7'b0000001};

        // Reset state, with requests and a response driven while reset is high
        reset = 1'b1;
        idle();
        if_req_valid_i   = 1'b1;
        dm_req_valid_i   = 1'b1;
        mem_ready_i      = 1'b1;
        mem_resp_valid_i = 1'b1;
        #2;
        chk("reset_outputs", {if_req_ready_o, dm_req_ready_o, mem_req_o, if_resp_valid_o,
                              dm_resp_valid_o, resp_err_o}, 6'b0);
        chk("reset_mem_resp_ready", mem_resp_ready_o, 1'b1);
        do_reset();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            if_req_valid_i   = tbl[i].ifv;
            if_req_addr_i    = 64'h1000 + 64'(i);
            dm_req_valid_i   = tbl[i].dmv;
            dm_req_addr_i    = 64'h8000 + 64'(i);
            dm_req_wr_i      = tbl[i].dmwr;
            dm_req_wr_data_i = 64'hA5A5_0000 + 64'(i);
            dm_req_mask_i    = 8'hFF;
            mem_ready_i      = tbl[i].rdy;
            mem_resp_valid_i = tbl[i].rv;
            mem_resp_data_i  = 64'hD000 + 64'(i);
            flush_i          = tbl[i].fl;
            #2;
            chk($sformatf("vec%0d", i), {if_req_ready_o, dm_req_ready_o, mem_req_o, mem_wr_o,
                                        if_resp_valid_o, dm_resp_valid_o, resp_err_o}, tbl[i].exp);
            next();
        end

        // Basic grant order and response routing
        do_reset();
        if_req_valid_i = 1'b1;  if_req_addr_i = 64'h2000;
        dm_req_valid_i = 1'b1;  dm_req_addr_i = 64'h100;
        mem_ready_i    = 1'b1;
        #2;
        chk("basic_dm_addr", mem_addr_o, 64'h100);
        chk("basic_dm_grant", {if_req_ready_o, dm_req_ready_o}, 2'b01);
        next();
        dm_req_valid_i = 1'b0;
        #2;
        chk("basic_if_addr", mem_addr_o, 64'h2000);
        chk("basic_if_grant", {if_req_ready_o, dm_req_ready_o, mem_wr_o}, 3'b100);
        next();
        idle();
        mem_resp_valid_i = 1'b1;  mem_resp_data_i = 64'hD0D0_0000_0000_00D0;
        #2;
        chk("basic_resp0_valid", {if_resp_valid_o, dm_resp_valid_o}, 2'b01);
        chk("basic_resp0_data", dm_resp_data_o, 64'hD0D0_0000_0000_00D0);
        next();
        mem_resp_data_i = 64'hD1D1_0000_0000_00D1;
        #2;
        chk("basic_resp1_valid", {if_resp_valid_o, dm_resp_valid_o}, 2'b10);
        chk("basic_resp1_data", if_resp_data_o, 64'hD1D1_0000_0000_00D1);
        next();

        // Starvation guard: four dm wins, then fetch, then dm again
        do_reset();
        if_req_valid_i = 1'b1;  if_req_addr_i = 64'h40;
        dm_req_valid_i = 1'b1;  dm_req_wr_i = 1'b1;  dm_req_addr_i = 64'h80;
        dm_req_mask_i  = 8'hFF;  mem_ready_i = 1'b1;
        for (int k = 0; k < LIM; k++) begin
            #2;
            chk($sformatf("starve_dm%0d", k), {if_req_ready_o, dm_req_ready_o}, 2'b01);
            next();
        end
        #2;
        chk("starve_if_wins", {if_req_ready_o, dm_req_ready_o}, 2'b10);
        next();
        #2;
        chk("starve_cleared", {if_req_ready_o, dm_req_ready_o}, 2'b01);
        next();

        // Tracker full: reads blocked, store still granted
        do_reset();
        if_req_valid_i = 1'b1;  mem_ready_i = 1'b1;
        next();
        next();
        dm_req_valid_i = 1'b1;
        #2;
        chk("full_blocks_reads", {if_req_ready_o, dm_req_ready_o, mem_req_o}, 3'b000);
        dm_req_wr_i      = 1'b1;
        dm_req_addr_i    = 64'h300;
        dm_req_wr_data_i = 64'h0000_0000_0000_DEAD;
        dm_req_mask_i    = 8'h0F;
        #1;
        chk("full_store_grant", {if_req_ready_o, dm_req_ready_o, mem_req_o, mem_wr_o}, 4'b0111);
        chk("full_store_mask", mem_mask_o, 8'h0F);
        chk("full_store_data", mem_wr_data_o, 64'h0000_0000_0000_DEAD);
        next();

        // Flush with two reads in flight: both responses swallowed
        idle();
        flush_i = 1'b1;
        next();
        flush_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid_i = 1'b1;  mem_resp_data_i = 64'(k + 7);
            #2;
            chk($sformatf("flush_drop%0d", k), {if_resp_valid_o, dm_resp_valid_o, resp_err_o}, 3'b000);
            next();
        end
        idle();
        if_req_valid_i = 1'b1;  mem_ready_i = 1'b1;
        next();
        idle();
        mem_resp_valid_i = 1'b1;  mem_resp_data_i = 64'h55;
        #2;
        chk("post_flush_fetch", {if_resp_valid_o, dm_resp_valid_o}, 2'b10);
        chk("post_flush_data", if_resp_data_o, 64'h55);
        next();

        // Reset mid-operation: stale response reports an error
        idle();
        if_req_valid_i = 1'b1;  mem_ready_i = 1'b1;
        next();
        idle();
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        mem_resp_valid_i = 1'b1;
        #2;
        chk("midreset_err", {resp_err_o, if_resp_valid_o, dm_resp_valid_o}, 3'b100);
        next();
        mem_resp_valid_i = 1'b0;
        #2;
        chk("midreset_err_pulse", resp_err_o, 1'b0);
        next();

        // Randomized traffic against the reference model
        do_reset();
        q.delete();
        starve = 0;
        for (int n = 0; n < 2000; n++) begin
            bit full, ife, dme, ifw, dmw, xfer, exp_if_rv, exp_dm_rv, exp_err;
            logic [63:0] exp_addr, exp_wdata;
            logic [7:0]  exp_mask;
            bit          exp_wr;
            if_req_valid_i   = 1'($urandom_range(0, 1));
            if_req_addr_i    = {$urandom, $urandom};
            dm_req_valid_i   = 1'($urandom_range(0, 1));
            dm_req_addr_i    = {$urandom, $urandom};
            dm_req_wr_i      = 1'($urandom_range(0, 1));
            dm_req_wr_data_i = {$urandom, $urandom};
            dm_req_mask_i    = 8'($urandom);
            mem_ready_i      = ($urandom_range(0, 3) != 0);
            mem_resp_valid_i = ($urandom_range(0, 2) == 0);
            mem_resp_data_i  = {$urandom, $urandom};
            flush_i          = ($urandom_range(0, 15) == 0);
            #2;

            full = (q.size() == MAXO);
            ife  = if_req_valid_i && !full && !flush_i;
            dme  = dm_req_valid_i && (dm_req_wr_i || !full) && !flush_i;
            ifw  = ife && (!dme || starve == LIM);
            dmw  = dme && !ifw;
            xfer = (ifw || dmw) && mem_ready_i;
            exp_addr  = !xfer ? 64'd0 : (ifw ? if_req_addr_i : dm_req_addr_i);
            exp_wr    = xfer && dmw && dm_req_wr_i;
            exp_wdata = exp_wr ? dm_req_wr_data_i : 64'd0;
            exp_mask  = exp_wr ? dm_req_mask_i : 8'd0;
            exp_err   = mem_resp_valid_i && (q.size() == 0);
            exp_if_rv = 0;
            exp_dm_rv = 0;
            if (mem_resp_valid_i && q.size() > 0 && !q[0].disc && !flush_i) begin
                exp_if_rv = !q[0].src;
                exp_dm_rv = q[0].src;
            end

            chk("rand_ctrl", {if_req_ready_o, dm_req_ready_o, mem_req_o, mem_wr_o,
                              if_resp_valid_o, dm_resp_valid_o, resp_err_o},
                {ifw && mem_ready_i, dmw && mem_ready_i, xfer, exp_wr, exp_if_rv, exp_dm_rv, exp_err});
            chk("rand_addr", mem_addr_o, exp_addr);
            chk("rand_wdata", mem_wr_data_o, exp_wdata);
            chk("rand_mask", {56'd0, mem_mask_o}, {56'd0, exp_mask});
            if (exp_if_rv) chk("rand_if_data", if_resp_data_o, mem_resp_data_i);
            if (exp_dm_rv) chk("rand_dm_data", dm_resp_data_o, mem_resp_data_i);

            if (mem_resp_valid_i && q.size() > 0) void'(q.pop_front());
            if (flush_i) foreach (q[j]) q[j].disc = 1;
            if (xfer && (ifw || !dm_req_wr_i)) q.push_back('{src: dmw, disc: 0});
            if (xfer && ifw) starve = 0;
            else if (xfer && dmw && ife && starve < LIM) starve++;
            next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
